pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Supervises the system/SDRAM PLL and produces the staged resets for the logic it clocks.
- Runs on the free-running 50 MHz board reference clock, which also feeds the PLL refclk.
- Drives the PLL reset input and consumes the PLL locked output.
- Releases SDRAM-controller reset first, then system reset, only after lock has been continuously stable; re-locks automatically on lock loss.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2)
- PLL_RST_CYCLES, 16, cycles pll_rst held high per PLL reset
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
- LOCK_TIMEOUT_CYCLES, 50000, cycles in WAIT_LOCK before the PLL is reset again (1 ms at 50 MHz)
- STAGE_GAP_CYCLES, 8, cycles between SDRAM release and system release, and between system release and ready
- CNT_W, 17, counter width; must hold the largest of the cycle parameters

Ports:
- clk  in  1  50 MHz reference clock
- reset_n  in  1  synchronous, active-low reset
- pll_locked  in  1  PLL locked, asynchronous to clk
- soft_reset_req  in  1  single-cycle request to re-sequence resets without resetting the PLL
- pll_rst  out  1  active-high reset to the PLL
- sdram_reset_n  out  1  active-low reset for the SDRAM controller domain
- sys_reset_n  out  1  active-low reset for the system domain
- ready  out  1  high when sequence complete and lock held
- relock_count  out  8  saturating count of PLL re-lock events
- state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered (Moore).
- Downstream domains re-synchronise reset deassertion in their own clock.
- reset_n low (sampled on clk edge) sets: state PLL_RESET, all counters 0, pll_rst=1, sdram_reset_n=0, sys_reset_n=0, ready=0, relock_count=0, sync flops 0.
- locked_s is pll_locked delayed through SYNC_STAGES flops. Only locked_s is used by the FSM.
- PLL_RESET: pll_rst=1, both resets low. Count PLL_RST_CYCLES cycles, then go to WAIT_LOCK with stable_cnt=0 and tmo_cnt=0.
- WAIT_LOCK: pll_rst=0, resets low.
  - stable_cnt increments while locked_s=1; it clears to 0 on any locked_s=0 cycle.
  - tmo_cnt increments every cycle.
  - locked_s=1 and stable_cnt==LOCK_STABLE_CYCLES-1 → RELEASE_SDRAM.
  - Otherwise tmo_cnt==LOCK_TIMEOUT_CYCLES-1 → PLL_RESET, relock_count+1.
  - If both are true in the same cycle, release wins.
- RELEASE_SDRAM: sdram_reset_n=1. After STAGE_GAP_CYCLES cycles → RELEASE_SYS.
- RELEASE_SYS: sdram_reset_n=1, sys_reset_n=1. After STAGE_GAP_CYCLES cycles → RUN.
- RUN: ready=1, both resets high.
- Lock loss: locked_s=0 in RELEASE_SDRAM, RELEASE_SYS or RUN → LOCK_LOST.
- LOCK_LOST: lasts 1 cycle; resets low, ready=0. relock_count+1 (saturates at 255), then → PLL_RESET.
- soft_reset_req=1 in RELEASE_SDRAM, RELEASE_SYS or RUN → WAIT_LOCK with counters cleared, so resets go low on the next cycle. No PLL reset and no relock_count change. The request is ignored in PLL_RESET, WAIT_LOCK and LOCK_LOST.
- Lock loss takes priority over soft_reset_req when both occur in the same cycle.
- Latency: first cycle with locked_s=1 at cycle t (uninterrupted) → sdram_reset_n high at t+LOCK_STABLE_CYCLES, sys_reset_n high STAGE_GAP_CYCLES later, ready high STAGE_GAP_CYCLES after that.
- Invariants:
  - sys_reset_n=1 implies sdram_reset_n=1.
  - ready=1 implies both resets are high.
  - pll_rst=1 implies both resets are low.
- State encoding: PLL_RESET=0, WAIT_LOCK=1, RELEASE_SDRAM=2, RELEASE_SYS=3, RUN=4, LOCK_LOST=5.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum and its encodings above;
  - default parameter constants;
  - the relock_count width (8).
- Sub-module bit_sync: parameterised SYNC_STAGES flop chain with synchronous active-low reset to 0, used for pll_locked.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, LOCK_TIMEOUT_CYCLES=64.
- Reset then pll_locked rises 10 cycles after reset release:
  - pll_rst is high for exactly 4 cycles.
  - sdram_reset_n rises 10 cycles after pll_locked (2 sync + 8 stable).
  - sys_reset_n rises 4 cycles after sdram_reset_n; ready rises 4 cycles after sys_reset_n.
  - relock_count=0.
- pll_locked glitches low for 1 cycle after 6 locked cycles in WAIT_LOCK → stable count restarts; release occurs 8 synced cycles after the glitch ends.
- pll_locked never asserts:
  - pll_rst re-pulses every 4+64 cycles.
  - relock_count reads 1, 2, 3; resets stay low; ready=0.
- pll_locked drops in RUN:
  - Both resets and ready go low 3 cycles later (2 sync + transition); relock_count=1.
  - pll_rst pulses for 4 cycles; full sequence repeats once lock returns.
- soft_reset_req pulse in RUN:
  - Resets go low next cycle; pll_rst stays 0; relock_count unchanged.
  - Release again after 8 stable cycles.
- soft_reset_req and lock loss in the same cycle → LOCK_LOST path taken; relock_count increments; PLL reset occurs.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding,
// default timing constants and a saturating increment helper.
package pll_seq_pkg;

  // Encodings are fixed so state_dbg can be decoded by software and scopes.
  typedef enum logic [2:0] {
    PLL_RESET     = 3'd0,
    WAIT_LOCK     = 3'd1,
    RELEASE_SDRAM = 3'd2,
    RELEASE_SYS   = 3'd3,
    RUN           = 3'd4,
    LOCK_LOST     = 3'd5
  } seq_state_t;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STAGE_GAP_CYCLES    = 8;
  localparam int DEF_CNT_W               = 17;

  localparam int RELOCK_W = 8;

  // Relock events are diagnostic only, so the count sticks at full scale
  // rather than wrapping back to a misleading small number.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a continuously stable
// lock, then releases the SDRAM-controller reset followed by the system
// reset. Any loss of lock tears both domains down and re-resets the PLL.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                soft_reset_req,
  output logic                pll_rst,
  output logic                sdram_reset_n,
  output logic                sys_reset_n,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [2:0]          state_dbg
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);

  seq_state_t          state;
  seq_state_t          state_next;
  logic [CNT_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]    phase_next;
  logic [CNT_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]    stable_next;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [CNT_W-1:0]    tmo_next;
  logic [RELOCK_W-1:0] relock_cnt;
  logic [RELOCK_W-1:0] relock_next;
  logic                locked_s;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  // State and counter registers; reset restarts the whole sequence.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= PLL_RESET;
      phase_cnt  <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      relock_cnt <= '0;
    end else begin
      state      <= state_next;
      phase_cnt  <= phase_next;
      stable_cnt <= stable_next;
      tmo_cnt    <= tmo_next;
      relock_cnt <= relock_next;
    end
  end

  // Next-state logic; every transition clears the counters so each state
  // starts timing from zero. Lock loss is checked ahead of a soft request.
  always_comb begin
    state_next  = state;
    phase_next  = phase_cnt;
    stable_next = stable_cnt;
    tmo_next    = tmo_cnt;
    relock_next = relock_cnt;

    case (state)
      PLL_RESET: begin
        if (phase_cnt == RST_LAST) begin
          state_next  = WAIT_LOCK;
          phase_next  = '0;
          stable_next = '0;
          tmo_next    = '0;
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end

      WAIT_LOCK: begin
        tmo_next    = tmo_cnt + 1'b1;
        stable_next = locked_s ? stable_cnt + 1'b1 : '0;
        if (locked_s && (stable_cnt == STABLE_LAST)) begin
          state_next  = RELEASE_SDRAM;
          phase_next  = '0;
          stable_next = '0;
          tmo_next    = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next  = PLL_RESET;
          phase_next  = '0;
          stable_next = '0;
          tmo_next    = '0;
          relock_next = sat_inc(relock_cnt);
        end
      end

      RELEASE_SDRAM, RELEASE_SYS, RUN: begin
        if (!locked_s) begin
          state_next  = LOCK_LOST;
          phase_next  = '0;
          stable_next = '0;
          tmo_next    = '0;
          relock_next = sat_inc(relock_cnt);
        end else if (soft_reset_req) begin
          state_next  = WAIT_LOCK;
          phase_next  = '0;
          stable_next = '0;
          tmo_next    = '0;
        end else if (state != RUN) begin
          if (phase_cnt == GAP_LAST) begin
            state_next = (state == RELEASE_SDRAM) ? RELEASE_SYS : RUN;
            phase_next = '0;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
      end

      LOCK_LOST: begin
        state_next  = PLL_RESET;
        phase_next  = '0;
        stable_next = '0;
        tmo_next    = '0;
      end

      default: begin
        state_next  = PLL_RESET;
        phase_next  = '0;
        stable_next = '0;
        tmo_next    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are
  // glitch-free and always line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pll_rst       <= 1'b1;
      sdram_reset_n <= 1'b0;
      sys_reset_n   <= 1'b0;
      ready         <= 1'b0;
    end else begin
      pll_rst       <= (state_next == PLL_RESET);
      sdram_reset_n <= (state_next == RELEASE_SDRAM) || (state_next == RELEASE_SYS) ||
                       (state_next == RUN);
      sys_reset_n   <= (state_next == RELEASE_SYS) || (state_next == RUN);
      ready         <= (state_next == RUN);
    end
  end

  assign relock_count = relock_cnt;
  assign state_dbg    = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: each stimulus step queues the
// output changes it should cause (cycle plus state/relock), and a monitor
// pops one entry every time the DUT's output vector changes.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int RST    = 4;
  localparam int STABLE = 8;
  localparam int GAP    = 4;
  localparam int TMO    = 64;

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_REL_SDRAM = 3'd2;
  localparam logic [2:0] S_REL_SYS   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_LOCK_LOST = 3'd5;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [7:0] rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sdram_reset_n;
  logic       sys_reset_n;
  logic       ready;
  logic [7:0] relock_count;
  logic [2:0] state_dbg;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [14:0] prev_vec = 'x;

  pll_reset_sequencer #(
    .SYNC_STAGES         (SYNC),
    .PLL_RST_CYCLES      (RST),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .STAGE_GAP_CYCLES    (GAP),
    .CNT_W               (17)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sdram_reset_n  (sdram_reset_n),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .relock_count   (relock_count),
    .state_dbg      (state_dbg)
  );

  // 50 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector implied by a state and relock count.
  function automatic logic [14:0] model_vec(input logic [2:0] st, input logic [7:0] rel);
    logic rst_o;
    logic sd_o;
    logic sy_o;
    logic rd_o;
    rst_o = (st == S_PLL_RESET);
    sd_o  = (st == S_REL_SDRAM) || (st == S_REL_SYS) || (st == S_RUN);
    sy_o  = (st == S_REL_SYS) || (st == S_RUN);
    rd_o  = (st == S_RUN);
    return {rst_o, sd_o, sy_o, rd_o, rel, st};
  endfunction

  task automatic expectEvent(input int at, input logic [2:0] st, input logic [7:0] rel);
    exp_t e;
    e.cyc = at;
    e.st  = st;
    e.rel = rel;
    sb.push_back(e);
  endtask

  // Drive inputs just after a rising edge, then hold them for 'hold' cycles.
  task automatic applyStimulus(input logic rn, input logic lk, input logic sr, input int hold);
    reset_n        = rn;
    pll_locked     = lk;
    soft_reset_req = sr;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [14:0] got, input int at);
    exp_t        e;
    logic [14:0] want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_change cycle %0d got %h want no change", at, got);
    end else begin
      e    = sb.pop_front();
      want = model_vec(e.st, e.rel);
      if ((got !== want) || (at != e.cyc)) begin
        errors++;
        $display("[TB] FAIL output_event got cycle %0d vec %h (state %0d relock %0d) want cycle %0d vec %h (state %0d relock %0d)",
                 at, got, got[2:0], got[10:3], e.cyc, want, e.st, e.rel);
      end
    end
  endtask

  // Monitor: sample mid-cycle and treat every change as a DUT response.
  always @(negedge clk) begin
    logic [14:0] cur;
    cur = {pll_rst, sdram_reset_n, sys_reset_n, ready, relock_count, state_dbg};
    if (cur !== prev_vec) begin
      checkOutput(cur, cyc);
      prev_vec = cur;
    end
  end

  initial begin
    int b;
    int r;

    // Power-on reset with no lock.
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    expectEvent(1, S_PLL_RESET, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    // Release reset: PLL reset lasts 4 cycles, then wait for lock.
    b = cyc;
    expectEvent(b + 4, S_WAIT_LOCK, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);

    // Lock arrives 10 cycles after release: 2 sync + 8 stable, then gaps.
    b = cyc;
    expectEvent(b + 10, S_REL_SDRAM, 8'd0);
    expectEvent(b + 14, S_REL_SYS,   8'd0);
    expectEvent(b + 18, S_RUN,       8'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);

    // Lock lost in RUN: teardown 3 cycles later, then a fresh PLL reset.
    b = cyc;
    expectEvent(b + 3, S_LOCK_LOST, 8'd1);
    expectEvent(b + 4, S_PLL_RESET, 8'd1);
    expectEvent(b + 8, S_WAIT_LOCK, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);

    // Lock returns: full sequence repeats.
    b = cyc;
    expectEvent(b + 10, S_REL_SDRAM, 8'd1);
    expectEvent(b + 14, S_REL_SYS,   8'd1);
    expectEvent(b + 18, S_RUN,       8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);

    // Soft reset in RUN: back to lock wait without touching the PLL.
    b = cyc;
    expectEvent(b + 1,  S_WAIT_LOCK, 8'd1);
    expectEvent(b + 9,  S_REL_SDRAM, 8'd1);
    expectEvent(b + 13, S_REL_SYS,   8'd1);
    expectEvent(b + 17, S_RUN,       8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);

    // Soft request arriving on the same edge the FSM sees lock loss.
    b = cyc;
    expectEvent(b + 3, S_LOCK_LOST, 8'd2);
    expectEvent(b + 4, S_PLL_RESET, 8'd2);
    expectEvent(b + 8, S_WAIT_LOCK, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 7);

    // Lock for 6 cycles, 1-cycle glitch, then steady: release 10 after recovery.
    b = cyc;
    expectEvent(b + 17, S_REL_SDRAM, 8'd2);
    expectEvent(b + 21, S_REL_SYS,   8'd2);
    expectEvent(b + 25, S_RUN,       8'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 30);

    // Reset from RUN, then the PLL never locks: re-pulse every 68 cycles.
    b = cyc;
    expectEvent(b + 1, S_PLL_RESET, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    r = cyc;
    expectEvent(r + 4,   S_WAIT_LOCK, 8'd0);
    expectEvent(r + 68,  S_PLL_RESET, 8'd1);
    expectEvent(r + 72,  S_WAIT_LOCK, 8'd1);
    expectEvent(r + 136, S_PLL_RESET, 8'd2);
    expectEvent(r + 140, S_WAIT_LOCK, 8'd2);
    expectEvent(r + 204, S_PLL_RESET, 8'd3);
    expectEvent(r + 208, S_WAIT_LOCK, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 212);

    // Every queued response must have been observed.
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events got %0d outstanding want 0 (next state %0d at cycle %0d)",
               sb.size(), sb[0].st, sb[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
